// File: rtl/sign_magnitude_converter_if.sv
// Handshake and data bundle for the bit-serial sign-magnitude converter.
// The requester drives en/A; the converter returns Magnitude/Sign/busy/ready.
interface sign_magnitude_converter_if;
  logic       en;
  logic [7:0] A;
  logic [7:0] Magnitude;
  logic       Sign;
  logic       busy;
  logic       ready;

  modport master (
    output en,
    output A,
    input  Magnitude,
    input  Sign,
    input  busy,
    input  ready
  );

  modport slave (
    input  en,
    input  A,
    output Magnitude,
    output Sign,
    output busy,
    output ready
  );
endinterface

// File: rtl/sign_magnitude_converter.sv
// Bit-serial two's-complement to sign-magnitude converter, 8-bit operand.
// One bit per clock, LSB first: bits are copied until the first 1 has
// passed, then inverted (only for negative operands). Fixed latency:
// accept on E0, bits on E1..E8, result + ready after E8, idle after E9.
module sign_magnitude_converter (
  input  logic                        clk,
  input  logic                        rst_n,
  sign_magnitude_converter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t     state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] res, res_n;
  logic [2:0] cnt, cnt_n;
  logic       neg, neg_n;
  logic       seen, seen_n;
  logic [7:0] mag_q, mag_n;
  logic       sign_q, sign_n;
  logic       busy_q, busy_n;
  logic       ready_q, ready_n;

  logic       bit_in;
  logic       out_bit;

  // Current operand bit and its converted value: invert only once a 1 has
  // already gone through and the operand is negative.
  assign bit_in  = shreg[0];
  assign out_bit = (neg & seen) ? ~bit_in : bit_in;

  assign bus.Magnitude = mag_q;
  assign bus.Sign      = sign_q;
  assign bus.busy      = busy_q;
  assign bus.ready     = ready_q;

  // Register all state; async reset drops any in-flight conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      res     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      seen    <= 1'b0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      res     <= res_n;
      cnt     <= cnt_n;
      neg     <= neg_n;
      seen    <= seen_n;
      mag_q   <= mag_n;
      sign_q  <= sign_n;
      busy_q  <= busy_n;
      ready_q <= ready_n;
    end
  end

  // Next-state and datapath: capture in IDLE, one bit per SHIFT cycle,
  // publish on the last bit, retire in DONE.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    res_n   = res;
    cnt_n   = cnt;
    neg_n   = neg;
    seen_n  = seen;
    mag_n   = mag_q;
    sign_n  = sign_q;
    busy_n  = busy_q;
    ready_n = 1'b0;

    case (state)
      IDLE: begin
        if (bus.en) begin
          shreg_n = bus.A;
          neg_n   = bus.A[7];
          cnt_n   = '0;
          seen_n  = 1'b0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        seen_n  = seen | bit_in;
        res_n   = {out_bit, res[7:1]};
        shreg_n = {1'b0, shreg[7:1]};
        cnt_n   = cnt + 3'd1;
        if (cnt == 3'd7) begin
          mag_n   = {out_bit, res[7:1]};
          sign_n  = neg;
          ready_n = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
